// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for a 5-stage RISC-V pipeline: branch redirect, multi-cycle EX op, load-use.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int FLUSH_CYCLES     = 2,
  parameter int MC_TIMEOUT       = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_memRead,
  input  logic [REG_NUM_BITWIDTH-1:0] id_Rd,
  input  logic [REG_NUM_BITWIDTH-1:0] if_Rs1,
  input  logic [REG_NUM_BITWIDTH-1:0] if_Rs2,
  input  logic                        PCSrc,
  input  logic                        mc_req,
  input  logic                        mc_done,
  output logic                        mc_go,
  output logic                        PCWrite,
  output logic                        if_write,
  output logic                        id_write,
  output logic                        if_doNOP,
  output logic                        id_doNOP,
  output logic                        ex_doNOP,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]                 lu_stall_cnt,
  output logic [31:0]                 flush_cnt_total,
  output logic [31:0]                 mc_stall_cnt,
`endif
  output logic                        mc_err
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int MW = $clog2(MC_TIMEOUT);

  typedef enum logic [1:0] {RUN, FLUSH, MC_WAIT} state_e;

  state_e          state_q, state_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [MW-1:0]   mc_cnt_q, mc_cnt_d;
  logic            mc_err_q, mc_err_d;
  logic            lu;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lu = id_memRead && (id_Rd != '0) && ((id_Rd == if_Rs1) || (id_Rd == if_Rs2));

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    mc_cnt_d    = mc_cnt_q;
    mc_err_d    = mc_err_q;
    mc_go       = 1'b0;
    PCWrite     = 1'b1;
    if_write    = 1'b1;
    id_write    = 1'b1;
    if_doNOP    = 1'b0;
    id_doNOP    = 1'b0;
    ex_doNOP    = 1'b0;

    if (rst) begin
      PCWrite     = 1'b0;
      if_write    = 1'b0;
      id_write    = 1'b0;
      if_doNOP    = 1'b1;
      id_doNOP    = 1'b1;
      ex_doNOP    = 1'b1;
      state_d     = RUN;
      flush_cnt_d = '0;
      mc_cnt_d    = '0;
      mc_err_d    = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (PCSrc) begin
            if_doNOP    = 1'b1;
            id_doNOP    = 1'b1;
            ex_doNOP    = 1'b1;
            flush_cnt_d = FW'(FLUSH_CYCLES - 1);
            state_d     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
          end else if (mc_req) begin
            mc_go    = 1'b1;
            PCWrite  = 1'b0;
            if_write = 1'b0;
            id_write = 1'b0;
            ex_doNOP = 1'b1;
            mc_cnt_d = '0;
            state_d  = MC_WAIT;
          end else if (lu) begin
            PCWrite  = 1'b0;
            if_write = 1'b0;
            id_doNOP = 1'b1;
          end
        end
        FLUSH: begin
          if_doNOP = 1'b1;
          if (PCSrc) begin
            id_doNOP    = 1'b1;
            ex_doNOP    = 1'b1;
            flush_cnt_d = FW'(FLUSH_CYCLES - 1);
          end else begin
            flush_cnt_d = flush_cnt_q - 1'b1;
            if (flush_cnt_q == FW'(1)) state_d = RUN;
          end
        end
        MC_WAIT: begin
          // A done pulse on the timeout cycle wins, so the error flag is not raised.
          if (mc_done) begin
            state_d = RUN;
          end else if (mc_cnt_q == MW'(MC_TIMEOUT - 1)) begin
            mc_err_d = 1'b1;
            state_d  = RUN;
          end else begin
            PCWrite  = 1'b0;
            if_write = 1'b0;
            id_write = 1'b0;
            ex_doNOP = 1'b1;
            if (mc_cnt_q != '1) mc_cnt_d = mc_cnt_q + 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    flush_cnt_q <= flush_cnt_d;
    mc_cnt_q    <= mc_cnt_d;
    mc_err_q    <= mc_err_d;
  end

  assign mc_err = mc_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic        lu_ev, flush_ev, mc_ev;
  logic [31:0] lu_stall_cnt_q, flush_cnt_total_q, mc_stall_cnt_q;

  assign lu_ev    = !rst && (state_q == RUN) && !PCSrc && !mc_req && lu;
  assign flush_ev = !rst && (state_q != MC_WAIT) && PCSrc;
  assign mc_ev    = !rst && (state_q == MC_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_stall_cnt_q    <= '0;
      flush_cnt_total_q <= '0;
      mc_stall_cnt_q    <= '0;
    end else begin
      if (lu_ev && lu_stall_cnt_q != '1)       lu_stall_cnt_q    <= lu_stall_cnt_q + 1'b1;
      if (flush_ev && flush_cnt_total_q != '1) flush_cnt_total_q <= flush_cnt_total_q + 1'b1;
      if (mc_ev && mc_stall_cnt_q != '1)       mc_stall_cnt_q    <= mc_stall_cnt_q + 1'b1;
    end
  end

  assign lu_stall_cnt    = lu_stall_cnt_q;
  assign flush_cnt_total = flush_cnt_total_q;
  assign mc_stall_cnt    = mc_stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2, MC_TIMEOUT=8).
module tb_pipeline_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst, id_memRead, PCSrc, mc_req, mc_done;
  logic [4:0] id_Rd, if_Rs1, if_Rs2;
  logic       mc_go, PCWrite, if_write, id_write, if_doNOP, id_doNOP, ex_doNOP, mc_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_stall_cnt, flush_cnt_total, mc_stall_cnt;
`endif
  int tests = 0;
  int failed = 0;

  // {mc_go, PCWrite, if_write, id_write, if_doNOP, id_doNOP, ex_doNOP}
  localparam logic [6:0] DEF  = 7'b0111000;
  localparam logic [6:0] RSTO = 7'b0000111;
  localparam logic [6:0] LU   = 7'b0001010;
  localparam logic [6:0] FL3  = 7'b0111111;
  localparam logic [6:0] FL1  = 7'b0111100;
  localparam logic [6:0] MCGO = 7'b1000001;
  localparam logic [6:0] MCW  = 7'b0000001;

  pipeline_hazard_ctrl #(.REG_NUM_BITWIDTH(5), .FLUSH_CYCLES(2), .MC_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .id_memRead(id_memRead), .id_Rd(id_Rd), .if_Rs1(if_Rs1),
    .if_Rs2(if_Rs2), .PCSrc(PCSrc), .mc_req(mc_req), .mc_done(mc_done), .mc_go(mc_go),
    .PCWrite(PCWrite), .if_write(if_write), .id_write(id_write), .if_doNOP(if_doNOP),
    .id_doNOP(id_doNOP), .ex_doNOP(ex_doNOP),
`ifdef HAZARD_PERF_CNT_EN
    .lu_stall_cnt(lu_stall_cnt), .flush_cnt_total(flush_cnt_total), .mc_stall_cnt(mc_stall_cnt),
`endif
    .mc_err(mc_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  function automatic logic [6:0] outs();
    return {mc_go, PCWrite, if_write, id_write, if_doNOP, id_doNOP, ex_doNOP};
  endfunction

  // Apply one cycle of inputs away from the rising edge and let the Mealy outputs settle.
  task automatic drive(input logic r, input logic m, input logic [4:0] rd, input logic [4:0] s1,
                       input logic [4:0] s2, input logic pc, input logic req, input logic done);
    @(negedge clk);
    rst = r; id_memRead = m; id_Rd = rd; if_Rs1 = s1; if_Rs2 = s2;
    PCSrc = pc; mc_req = req; mc_done = done;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
  endtask

  task automatic test_reset();
    drive(1, 1, 5'd5, 5'd5, 5'd0, 1, 1, 0);
    tests++;
    if (outs() !== RSTO) begin failed++; $display("FAIL reset_outputs got %b expected %b", outs(), RSTO); end
    idle();
    tests++;
    if (outs() !== DEF) begin failed++; $display("FAIL reset_then_default got %b expected %b", outs(), DEF); end
    tests++;
    if (mc_err !== 1'b0) begin failed++; $display("FAIL reset_mc_err got %b expected 0", mc_err); end
    $display("[TB] reset: outputs=%b", outs());
  endtask

  task automatic test_load_use();
    drive(0, 1, 5'd5, 5'd3, 5'd5, 0, 0, 0);
    tests++;
    if (outs() !== LU) begin failed++; $display("FAIL lu_rs2 got %b expected %b", outs(), LU); end
    idle();
    tests++;
    if (outs() !== DEF) begin failed++; $display("FAIL lu_one_cycle got %b expected %b", outs(), DEF); end
    drive(0, 1, 5'd7, 5'd7, 5'd1, 0, 0, 0);
    tests++;
    if (outs() !== LU) begin failed++; $display("FAIL lu_rs1 got %b expected %b", outs(), LU); end
    drive(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    tests++;
    if (outs() !== DEF) begin failed++; $display("FAIL lu_x0 got %b expected %b", outs(), DEF); end
    drive(0, 0, 5'd9, 5'd9, 5'd9, 0, 0, 0);
    tests++;
    if (outs() !== DEF) begin failed++; $display("FAIL lu_no_load got %b expected %b", outs(), DEF); end
    drive(0, 1, 5'd4, 5'd6, 5'd8, 0, 0, 0);
    tests++;
    if (outs() !== DEF) begin failed++; $display("FAIL lu_no_match got %b expected %b", outs(), DEF); end
    $display("[TB] load_use: done");
  endtask

  task automatic test_branch();
    drive(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    tests++;
    if (outs() !== FL3) begin failed++; $display("FAIL branch_c0 got %b expected %b", outs(), FL3); end
    // lu and mc_req in FLUSH are ignored
    drive(0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0);
    tests++;
    if (outs() !== FL1) begin failed++; $display("FAIL branch_c1 got %b expected %b", outs(), FL1); end
    idle();
    tests++;
    if (outs() !== DEF) begin failed++; $display("FAIL branch_c2 got %b expected %b", outs(), DEF); end
    $display("[TB] branch: done");
  endtask

  task automatic test_priority();
    drive(0, 1, 5'd5, 5'd0, 5'd5, 1, 1, 0);
    tests++;
    if (outs() !== FL3) begin failed++; $display("FAIL prio_c0 got %b expected %b", outs(), FL3); end
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    tests++;
    if (outs() !== FL1) begin failed++; $display("FAIL prio_flush_state got %b expected %b", outs(), FL1); end
    idle();
    tests++;
    if (outs() !== DEF) begin failed++; $display("FAIL prio_after got %b expected %b", outs(), DEF); end
    $display("[TB] priority: done");
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    drive(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    tests++;
    if (outs() !== FL3) begin failed++; $display("FAIL b2b_refflush got %b expected %b", outs(), FL3); end
    idle();
    tests++;
    if (outs() !== FL1) begin failed++; $display("FAIL b2b_reload got %b expected %b", outs(), FL1); end
    idle();
    tests++;
    if (outs() !== DEF) begin failed++; $display("FAIL b2b_end got %b expected %b", outs(), DEF); end
    $display("[TB] back_to_back: done");
  endtask

  task automatic test_mc_op();
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    tests++;
    if (outs() !== MCGO) begin failed++; $display("FAIL mc_go_cycle got %b expected %b", outs(), MCGO); end
    for (int c = 1; c <= 4; c++) begin
      // PCSrc and lu during MC_WAIT are ignored
      drive(0, c == 3, 5'd5, 5'd5, 5'd0, c == 2, 1, 0);
      tests++;
      if (outs() !== MCW) begin failed++; $display("FAIL mc_wait_c%0d got %b expected %b", c, outs(), MCW); end
    end
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
    tests++;
    if (outs() !== DEF) begin failed++; $display("FAIL mc_release got %b expected %b", outs(), DEF); end
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    tests++;
    if (outs() !== DEF) begin failed++; $display("FAIL mc_after_release got %b expected %b", outs(), DEF); end
    tests++;
    if (mc_err !== 1'b0) begin failed++; $display("FAIL mc_err_clean got %b expected 0", mc_err); end
    $display("[TB] mc_op: done");
  endtask

  task automatic test_done_on_timeout();
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    for (int c = 1; c <= 7; c++) drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    tests++;
    if (outs() !== MCW) begin failed++; $display("FAIL dto_last_stall got %b expected %b", outs(), MCW); end
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
    tests++;
    if (outs() !== DEF) begin failed++; $display("FAIL dto_release got %b expected %b", outs(), DEF); end
    idle();
    tests++;
    if (mc_err !== 1'b0) begin failed++; $display("FAIL dto_mc_err got %b expected 0", mc_err); end
    $display("[TB] done_on_timeout: mc_err=%b", mc_err);
  endtask

  task automatic test_timeout();
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    for (int c = 1; c <= 7; c++) drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    tests++;
    if (outs() !== MCW) begin failed++; $display("FAIL to_7th_wait got %b expected %b", outs(), MCW); end
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    tests++;
    if (outs() !== DEF) begin failed++; $display("FAIL to_release got %b expected %b", outs(), DEF); end
    idle();
    tests++;
    if (mc_err !== 1'b1) begin failed++; $display("FAIL to_mc_err_set got %b expected 1", mc_err); end
    tests++;
    if (outs() !== DEF) begin failed++; $display("FAIL to_run_after got %b expected %b", outs(), DEF); end
    idle(); idle();
    tests++;
    if (mc_err !== 1'b1) begin failed++; $display("FAIL to_mc_err_sticky got %b expected 1", mc_err); end
    drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    idle();
    tests++;
    if (mc_err !== 1'b0) begin failed++; $display("FAIL to_mc_err_cleared got %b expected 0", mc_err); end
    $display("[TB] timeout: done");
  endtask

  task automatic test_reset_mid_op();
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    tests++;
    if (outs() !== RSTO) begin failed++; $display("FAIL rst_mid_wait_out got %b expected %b", outs(), RSTO); end
    idle();
    tests++;
    if (outs() !== DEF) begin failed++; $display("FAIL rst_mid_wait_run got %b expected %b", outs(), DEF); end
    drive(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    idle();
    tests++;
    if (outs() !== DEF) begin failed++; $display("FAIL rst_mid_flush_run got %b expected %b", outs(), DEF); end
    $display("[TB] reset_mid_op: done");
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 5'd5, 5'd0, 5'd5, 0, 0, 0);
      idle();
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
      idle(); idle();
    end
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    for (int c = 1; c <= 4; c++) drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
    idle();
    tests++;
    if (lu_stall_cnt !== 32'd3) begin failed++; $display("FAIL perf_lu got %0d expected 3", lu_stall_cnt); end
    tests++;
    if (flush_cnt_total !== 32'd2) begin failed++; $display("FAIL perf_flush got %0d expected 2", flush_cnt_total); end
    tests++;
    if (mc_stall_cnt !== 32'd5) begin failed++; $display("FAIL perf_mc got %0d expected 5", mc_stall_cnt); end
    $display("[TB] perf: lu=%0d flush=%0d mc=%0d", lu_stall_cnt, flush_cnt_total, mc_stall_cnt);
  endtask
`endif

  initial begin
    rst = 1'b1; id_memRead = 1'b0; id_Rd = '0; if_Rs1 = '0; if_Rs2 = '0;
    PCSrc = 1'b0; mc_req = 1'b0; mc_done = 1'b0;
    test_reset();
    test_load_use();
    test_branch();
    test_priority();
    test_back_to_back();
    test_mc_op();
    test_done_on_timeout();
    test_timeout();
    test_reset_mid_op();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
